// File: rtl/hex_rx_parser_if.sv
// hex_rx_parser_if: serial input and parsed-word outputs of hex_rx_parser.
// HEX_RX_PARSER_CHAR_OUT_EN adds the raw received byte (rxch/rxchv).
interface hex_rx_parser_if;
    logic        rxd;
    logic [31:0] word;
    logic        word_v;
    logic [3:0]  ndig;
    logic        ovf;
    logic        err_v;
`ifdef HEX_RX_PARSER_CHAR_OUT_EN
    logic [7:0]  rxch;
    logic        rxchv;
    modport master (input rxd, output word, word_v, ndig, ovf, err_v, rxch, rxchv);
    modport slave (output rxd, input word, word_v, ndig, ovf, err_v, rxch, rxchv);
`else
    modport master (input rxd, output word, word_v, ndig, ovf, err_v);
    modport slave (output rxd, input word, word_v, ndig, ovf, err_v);
`endif
endinterface

// File: rtl/hex_rx_parser.sv
// hex_rx_parser: UART 8N1 receiver feeding an ASCII-hex line parser that emits 32-bit words on CR/LF.
// HEX_RX_PARSER_CHAR_OUT_EN exposes every good byte on rxch/rxchv.
module hex_rx_parser #(
    parameter int PULSEW  = 5208,
    parameter int PULSEW2 = 2604
) (
    input logic             clk,
    input logic             rstn,
    hex_rx_parser_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t      state;
    logic        s1, s2, s3;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh, rx_byte;
    logic        byte_v;
    logic [31:0] acc, word;
    logic [3:0]  ndig;
    logic        ovf, word_v, err_v;
    logic        is_hex, is_eol, is_esc, is_sp;
    logic [3:0]  nib;
    always_comb begin
        is_hex = rx_byte inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]};
        is_eol = rx_byte == 8'h0D || rx_byte == 8'h0A;
        is_esc = rx_byte == 8'h1B;
        is_sp  = rx_byte == 8'h20;
        nib    = rx_byte[6] ? rx_byte[3:0] + 4'd9 : rx_byte[3:0];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            rx_byte <= '0;
            byte_v  <= 1'b0;
            acc     <= '0;
            word    <= '0;
            ndig    <= '0;
            ovf     <= 1'b0;
            word_v  <= 1'b0;
            err_v   <= 1'b0;
        end else begin
            s1     <= bus.rxd;
            s2     <= s1;
            s3     <= s2;
            byte_v <= 1'b0;
            word_v <= 1'b0;
            err_v  <= 1'b0;
            case (state)
                IDLE: if (s3 && !s2) begin
                    cnt   <= 16'(PULSEW2 - 1);
                    state <= START;
                end
                START: if (cnt != 16'd0) cnt <= cnt - 16'd1;
                else if (s2) state <= IDLE;
                else begin
                    cnt   <= 16'(PULSEW - 1);
                    idx   <= 3'd0;
                    state <= DATA;
                end
                DATA: if (cnt != 16'd0) cnt <= cnt - 16'd1;
                else begin
                    sh    <= {s2, sh[7:1]};
                    cnt   <= 16'(PULSEW - 1);
                    idx   <= idx + 3'd1;
                    state <= idx == 3'd7 ? STOP : DATA;
                end
                STOP: if (cnt != 16'd0) cnt <= cnt - 16'd1;
                else begin
                    state <= IDLE;
                    if (s2) begin
                        rx_byte <= sh;
                        byte_v  <= 1'b1;
                    end else err_v <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // Parser runs one cycle behind the stop sample, on the latched byte.
            if (byte_v) begin
                if (is_hex) begin
                    acc  <= {acc[27:0], nib};
                    ndig <= ndig == 4'd8 ? ndig : ndig + 4'd1;
                    ovf  <= ovf | (ndig == 4'd8);
                end else if (is_eol) begin
                    if (ndig != 4'd0) begin
                        word   <= acc;
                        word_v <= 1'b1;
                        acc    <= '0;
                        ndig   <= '0;
                        ovf    <= 1'b0;
                    end
                end else if (!is_sp) begin
                    acc   <= '0;
                    ndig  <= '0;
                    ovf   <= 1'b0;
                    err_v <= !is_esc;
                end
            end
        end
    end
    assign bus.word   = word;
    assign bus.word_v = word_v;
    assign bus.ndig   = ndig;
    assign bus.ovf    = ovf;
    assign bus.err_v  = err_v;
`ifdef HEX_RX_PARSER_CHAR_OUT_EN
    assign bus.rxch   = rx_byte;
    assign bus.rxchv  = byte_v;
`endif
endmodule

// File: tb/tb_hex_rx_parser.sv
// tb_hex_rx_parser: table-driven byte vectors through the UART line, plus glitch and reset sequences.
module tb_hex_rx_parser;
    localparam int PW = 16;
    typedef struct {
        logic [7:0]  ch;
        bit          stop;
        int          gap;
        logic [31:0] word;
        int          wv;
        int          er;
        int          nd;
        bit          ov;
    } vec_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0, errors = 0;
    int   nwv = 0, nerr = 0, nch = 0, wide = 0;
    logic pwv = 1'b0, perr = 1'b0;
    vec_t tv[$];
    hex_rx_parser_if bus();
    hex_rx_parser #(.PULSEW(16), .PULSEW2(8)) dut (.clk(clk), .rstn(rstn), .bus(bus.master));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.word_v) nwv++;
        if (bus.err_v) nerr++;
        if ((bus.word_v && pwv) || (bus.err_v && perr)) wide++;
        pwv = bus.word_v;
        perr = bus.err_v;
`ifdef HEX_RX_PARSER_CHAR_OUT_EN
        if (bus.rxchv) nch++;
`endif
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic send(input logic [7:0] b, input bit stop);
        bus.rxd = 1'b0;
        repeat (PW) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (PW) @(negedge clk);
        end
        bus.rxd = stop;
        repeat (PW) @(negedge clk);
        bus.rxd = 1'b1;
    endtask
    function automatic void add(input logic [7:0] ch, input bit stop, input logic [31:0] w,
                                input int wv, input int er, input int nd, input bit ov);
        vec_t v;
        v.ch = ch; v.stop = stop; v.gap = stop ? 0 : 20;
        v.word = w; v.wv = wv; v.er = er; v.nd = nd; v.ov = ov;
        tv.push_back(v);
    endfunction
    task automatic run_vec(input vec_t v);
        int bwv, ber, bch;
        bwv = nwv; ber = nerr; bch = nch;
        send(v.ch, v.stop);
        repeat (v.gap) @(negedge clk);
        chk($sformatf("word@%h", v.ch), bus.word, v.word);
        chk($sformatf("word_v@%h", v.ch), nwv - bwv, v.wv);
        chk($sformatf("err_v@%h", v.ch), nerr - ber, v.er);
        chk($sformatf("ndig@%h", v.ch), 32'(bus.ndig), v.nd);
        chk($sformatf("ovf@%h", v.ch), 32'(bus.ovf), 32'(v.ov));
`ifdef HEX_RX_PARSER_CHAR_OUT_EN
        chk($sformatf("rxchv@%h", v.ch), nch - bch, v.stop ? 1 : 0);
        if (v.stop) chk($sformatf("rxch@%h", v.ch), 32'(bus.rxch), 32'(v.ch));
`endif
    endtask
    initial begin
        string s;
        int    bwv, ber;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_word", bus.word, 0);
        chk("rst_ndig", 32'(bus.ndig), 0);
        chk("rst_pulses", {bus.word_v, bus.err_v, bus.ovf}, 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        // 3-cycle low glitch must be rejected at the start-bit check.
        ber = nerr;
        bus.rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_err", nerr - ber, 0);
        add("G", 1, 0, 0, 1, 0, 0);
        add(8'h0D, 1, 0, 0, 0, 0, 0);
        s = "DEADBEEF";
        for (int i = 0; i < 8; i++) add(s[i], 1, 0, 0, 0, i + 1, 0);
        add(8'h0D, 1, 32'hDEADBEEF, 1, 0, 0, 0);
        s = "12ab";
        for (int i = 0; i < 4; i++) add(s[i], 1, 32'hDEADBEEF, 0, 0, i + 1, 0);
        add(8'h0D, 1, 32'h000012AB, 1, 0, 0, 0);
        add(8'h0A, 1, 32'h000012AB, 0, 0, 0, 0);
        s = "12345678";
        for (int i = 0; i < 8; i++) add(s[i], 1, 32'h000012AB, 0, 0, i + 1, 0);
        add("9", 1, 32'h000012AB, 0, 0, 8, 1);
        add(8'h0D, 1, 32'h23456789, 1, 0, 0, 0);
        add(8'h41, 0, 32'h23456789, 0, 1, 0, 0);
        add("5", 1, 32'h23456789, 0, 0, 1, 0);
        add(8'h0D, 1, 32'h00000005, 1, 0, 0, 0);
        add("9", 1, 32'h00000005, 0, 0, 1, 0);
        add(8'h41, 0, 32'h00000005, 0, 1, 1, 0);
        add(8'h0D, 1, 32'h00000009, 1, 0, 0, 0);
        add("3", 1, 32'h00000009, 0, 0, 1, 0);
        add(" ", 1, 32'h00000009, 0, 0, 1, 0);
        add(8'h1B, 1, 32'h00000009, 0, 0, 0, 0);
        add(8'h0D, 1, 32'h00000009, 0, 0, 0, 0);
        add("4", 1, 32'h00000009, 0, 0, 1, 0);
        add("G", 1, 32'h00000009, 0, 1, 0, 0);
        add("A", 1, 32'h00000009, 0, 0, 1, 0);
        add("B", 1, 32'h00000009, 0, 0, 2, 0);
        foreach (tv[i]) run_vec(tv[i]);
        // Reset in the middle of 'C' (0x43): start bit plus two data bits, then rstn low.
        bus.rxd = 1'b0;
        repeat (PW) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (2 * PW) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_word", bus.word, 0);
        chk("midrst_ndig", 32'(bus.ndig), 0);
        chk("midrst_pulses", {bus.word_v, bus.err_v, bus.ovf}, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8 * PW) @(negedge clk);
        bwv = nwv; ber = nerr;
        send("7", 1);
        chk("post_rst_ndig", 32'(bus.ndig), 1);
        send(8'h0D, 1);
        chk("post_rst_word", bus.word, 32'h00000007);
        chk("post_rst_word_v", nwv - bwv, 1);
        chk("post_rst_err", nerr - ber, 0);
        chk("pulse_width", wide, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
